mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  Parametrised memory stage with a load/store unit. Sits between EX and WB.
//  Drives an external data-memory port with a req/gnt/rvalid handshake that tolerates variable latency.
//  Generates byte enables, aligns store data, and sign/zero-extends load data.
//  Stalls the pipeline until the access completes; ALU results pass straight through.
// PARAMETERS
//  DATA_WIDTH  32  datapath/bus width; legal values 32 or 64
//  ADDR_WIDTH  32  dmem address width
//  BE_WIDTH    DATA_WIDTH/8  derived; byte enables per beat
// PORTS
//  clk           in   1            clock
//  arst          in   1            reset, asynchronous, active-high
//  in_valid      in   1            mem_stage_in holds a valid instruction
//  mem_stage_in  in   mem_stage_in_t   opr_res, rs2_data, rd, wb_en, wb_sel, mem_rd, mem_wr, mem_size, mem_unsigned
//  mem_stage_out out  mem_stage_out_t  opr_res, dmem_rdata, rd, wb_en, wb_sel
//  stall         out  1            hold EX/MEM register and upstream
//  misaligned    out  1            access-fault indication; one cycle per offending instruction
//  dmem_req      out  1            request valid
//  dmem_we       out  1            1 = store
//  dmem_addr     out  ADDR_WIDTH   word-aligned address (low offset bits zeroed)
//  dmem_be       out  BE_WIDTH     byte enables
//  dmem_wdata    out  DATA_WIDTH   lane-aligned store data
//  dmem_gnt      in   1            request accepted
//  dmem_rvalid   in   1            read data valid
//  dmem_rdata    in   DATA_WIDTH   read data
// BEHAVIOUR
//  Reset
//   - arst high: state=IDLE, rdata_q=0.
//   - dmem_req, stall and misaligned are forced 0 while arst is high.
//   - Reset mid-access abandons the access; no response is expected afterwards.
//  Sizes
//   - mem_size: 00=B, 01=H, 10=W, 11=D. D is legal only when DATA_WIDTH=64.
//   - Misaligned when: H with off[0]!=0; W with off[1:0]!=0; D with off!=0; or D at DATA_WIDTH=32.
//   - off = opr_res[log2(BE_WIDTH)-1:0].
//  Stores
//   - dmem_be = size-mask << off.
//   - dmem_wdata = rs2_data low bytes replicated across all lanes.
//  Loads
//   - rdata shifted right by off*8, then truncated to size.
//   - Extension is sign, or zero when mem_unsigned=1.
//  Non-memory op, or in_valid=0
//   - Outputs are a combinational pass-through.
//   - stall=0, dmem_req=0, dmem_rdata=0.
//  Misaligned op in IDLE
//   - No request is issued; misaligned=1 for that cycle.
//   - mem_stage_out.wb_en forced 0; stall=0; state stays IDLE.
//  FSM (lsu_state_e)
//   - IDLE: on a valid, aligned mem op: dmem_req=1, stall=1.
//     gnt -> (we ? RESP : WAIT); no gnt -> REQ.
//   - REQ: dmem_req=1, stall=1.
//     gnt -> (we ? RESP : WAIT).
//   - WAIT: dmem_req=0, stall=1.
//     On rvalid: rdata_q <= extended load data; -> RESP.
//   - RESP: stall=0; mem_stage_out.dmem_rdata=rdata_q; -> IDLE unconditionally.
//  Handshake rules
//   - Request fields depend only on mem_stage_in and must stay stable from req until gnt; the held input guarantees this.
//   - One outstanding access at a time; a new req is never issued in WAIT or RESP.
//   - rvalid arrives >=1 cycle after gnt. rvalid outside WAIT is ignored; an SVA flags it.
//  Latency
//   - Store with immediate gnt: 2 cycles (IDLE, RESP).
//   - Load with immediate gnt and next-cycle rvalid: 3 cycles.
//   - Each gnt/rvalid wait cycle adds one cycle.
//  Pass-through
//   - opr_res, rd and wb_sel always pass through.
//   - wb_en passes through except on a misaligned access.
// STRUCTURE
//  mem_stage_pkg holds:
//   - mem_size_e, lsu_state_e
//   - the extended mem_stage_in_t / mem_stage_out_t
//   - size-mask function
//  Sub-module lsu_align (combinational): be/wdata generation, load extract/extend, misalign detect.
//  mem_stage_lsu keeps the FSM, rdata_q and the stall logic.
// TESTING
//  1. ADD (no mem op), opr_res=0x1234 -> stall=0, dmem_req=0, out.opr_res=0x1234 same cycle.
//  2. SW addr=0x104, rs2=0xDEADBEEF, gnt held 0 for 3 cycles
//     -> dmem_req/stall high 4 cycles, be=4'b1111, wdata=0xDEADBEEF, stall drops in RESP.
//  3. LB addr=0x103, rdata=0x80FF_0000, rvalid 2 cycles after gnt
//     -> out.dmem_rdata=0xFFFFFF80.
//     LBU same address -> 0x00000080.
//  4. SH addr=0x102, rs2=0xABCD -> be=4'b1100, wdata=0xABCDABCD.
//     LH addr=0x101 -> misaligned=1 one cycle, dmem_req=0, wb_en=0.
//  5. DATA_WIDTH=64, LD addr=0x8 -> be=8'hFF, full 64-bit data returned.
//     LW addr=0xC -> be=8'hF0, data taken from upper lanes.
//  6. arst pulsed while in WAIT
//     -> stall=0, dmem_req=0 immediately; late rvalid ignored.
//     Next LW completes normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types for the memory stage.
//   mem_size_e      access size encoding (B/H/W/D)
//   lsu_state_e     LSU handshake FSM states
//   mem_stage_in_t  EX/MEM register contents consumed by the memory stage
//   mem_stage_out_t MEM/WB payload produced by the memory stage
//   size_mask()     byte mask of an access size, before shifting to its offset
// Data fields are sized for the widest legal datapath (MAX_XLEN); a 32-bit
// instance only uses the low half of opr_res/rs2_data/dmem_rdata.
package mem_stage_pkg;

  localparam int MAX_XLEN = 64;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_D = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic [MAX_XLEN-1:0]   opr_res;
    logic [MAX_XLEN-1:0]   rs2_data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wb_en;
    logic [1:0]            wb_sel;
    logic                  mem_rd;
    logic                  mem_wr;
    mem_size_e             mem_size;
    logic                  mem_unsigned;
  } mem_stage_in_t;

  typedef struct packed {
    logic [MAX_XLEN-1:0]   opr_res;
    logic [MAX_XLEN-1:0]   dmem_rdata;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wb_en;
    logic [1:0]            wb_sel;
  } mem_stage_out_t;

  function automatic logic [7:0] size_mask(input mem_size_e size);
    case (size)
      SIZE_B:  return 8'h01;
      SIZE_H:  return 8'h03;
      SIZE_W:  return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// lsu_align: combinational lane logic of the load/store unit.
//   off          byte offset of the access inside a bus beat
//   mem_size     access size
//   mem_unsigned 1 = zero-extend loads, 0 = sign-extend
//   store_data   register data to be stored
//   load_data    raw bus read data
//   be           byte enables (size mask shifted to the offset)
//   wdata        store data replicated into every lane
//   load_ext     load data shifted down to lane 0, truncated and extended
//   misaligned   access does not fit its natural alignment / the bus
module lsu_align
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int OFF_W      = $clog2(BE_WIDTH)
) (
  input  logic [OFF_W-1:0]      off,
  input  mem_size_e             mem_size,
  input  logic                  mem_unsigned,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic [BE_WIDTH-1:0]   be,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_ext,
  output logic                  misaligned
);

  logic [7:0]            mask8;
  logic [BE_WIDTH-1:0]   size_be;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] keep;
  logic                  sign_bit;
  logic                  unused_mask;

  assign mask8       = size_mask(mem_size);
  assign size_be     = mask8[BE_WIDTH-1:0];
  // Upper mask bits are only meaningful on a 64-bit bus.
  assign unused_mask = ^mask8;
  assign be          = size_be << off;

  assign shifted = load_data >> {off, 3'b000};

  // Bit mask covering the bytes of the access once moved down to lane 0.
  for (genvar gi = 0; gi < BE_WIDTH; gi++) begin : g_keep
    assign keep[8*gi +: 8] = {8{size_be[gi]}};
  end

  always_comb begin
    sign_bit = 1'b0;
    wdata    = store_data;
    case (mem_size)
      SIZE_B: begin
        sign_bit = shifted[7];
        wdata    = {BE_WIDTH{store_data[7:0]}};
      end
      SIZE_H: begin
        sign_bit = shifted[15];
        wdata    = {(BE_WIDTH/2){store_data[15:0]}};
      end
      SIZE_W: begin
        sign_bit = shifted[31];
        wdata    = {(BE_WIDTH/4){store_data[31:0]}};
      end
      default: begin
        sign_bit = shifted[DATA_WIDTH-1];
        wdata    = store_data;
      end
    endcase
  end

  assign load_ext = (shifted & keep) | ((sign_bit && !mem_unsigned) ? ~keep : '0);

  always_comb begin
    misaligned = 1'b0;
    case (mem_size)
      SIZE_B:  misaligned = 1'b0;
      SIZE_H:  misaligned = off[0];
      SIZE_W:  misaligned = (off[1:0] != 2'b00);
      default: misaligned = (DATA_WIDTH == 32) || (off != '0);
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory stage between EX and WB with a load/store unit.
//   clk, arst          clock; asynchronous active-high reset
//   in_valid           mem_stage_in holds a valid instruction
//   mem_stage_in       EX/MEM register contents
//   mem_stage_out      MEM/WB payload (ALU result pass-through + load data)
//   stall              hold EX/MEM register and everything upstream
//   misaligned         one-cycle fault flag for a misaligned access
//   dmem_*             data-memory port with req/gnt/rvalid handshake
// The EX/MEM register is held while stall=1, so the request fields derived
// from mem_stage_in are stable from req until gnt without extra registers.
module mem_stage_lsu
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  in_valid,
  input  mem_stage_in_t         mem_stage_in,
  output mem_stage_out_t        mem_stage_out,
  output logic                  stall,
  output logic                  misaligned,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [BE_WIDTH-1:0]   dmem_be,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata
);

  localparam int OFF_W = $clog2(BE_WIDTH);

  lsu_state_e            state_reg, state_next;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic [DATA_WIDTH-1:0] load_ext;
  logic                  align_fault;
  logic                  mem_op;
  logic                  req_raw, stall_raw, mis_raw;
  logic                  unused_wide;

  // Wide struct fields: only the low DATA_WIDTH/ADDR_WIDTH bits are used.
  assign unused_wide = ^{mem_stage_in.opr_res, mem_stage_in.rs2_data};

  assign mem_op = in_valid && (mem_stage_in.mem_rd || mem_stage_in.mem_wr);

  lsu_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .BE_WIDTH   (BE_WIDTH),
    .OFF_W      (OFF_W)
  ) u_align (
    .off          (mem_stage_in.opr_res[OFF_W-1:0]),
    .mem_size     (mem_stage_in.mem_size),
    .mem_unsigned (mem_stage_in.mem_unsigned),
    .store_data   (mem_stage_in.rs2_data[DATA_WIDTH-1:0]),
    .load_data    (dmem_rdata),
    .be           (dmem_be),
    .wdata        (dmem_wdata),
    .load_ext     (load_ext),
    .misaligned   (align_fault)
  );

  assign dmem_we   = mem_stage_in.mem_wr;
  assign dmem_addr = {mem_stage_in.opr_res[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_reg <= IDLE;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == WAIT && dmem_rvalid) begin
        rdata_reg <= load_ext;
      end
    end
  end

  always_comb begin
    state_next               = state_reg;
    req_raw                  = 1'b0;
    stall_raw                = 1'b0;
    mis_raw                  = 1'b0;
    mem_stage_out.opr_res    = mem_stage_in.opr_res;
    mem_stage_out.dmem_rdata = '0;
    mem_stage_out.rd         = mem_stage_in.rd;
    mem_stage_out.wb_en      = mem_stage_in.wb_en;
    mem_stage_out.wb_sel     = mem_stage_in.wb_sel;
    case (state_reg)
      IDLE: begin
        if (mem_op) begin
          if (align_fault) begin
            // Faulting access retires immediately without touching memory.
            mis_raw             = 1'b1;
            mem_stage_out.wb_en = 1'b0;
          end else begin
            req_raw   = 1'b1;
            stall_raw = 1'b1;
            if (dmem_gnt) begin
              state_next = mem_stage_in.mem_wr ? RESP : WAIT;
            end else begin
              state_next = REQ;
            end
          end
        end
      end
      REQ: begin
        req_raw   = 1'b1;
        stall_raw = 1'b1;
        if (dmem_gnt) begin
          state_next = mem_stage_in.mem_wr ? RESP : WAIT;
        end
      end
      WAIT: begin
        stall_raw = 1'b1;
        if (dmem_rvalid) begin
          state_next = RESP;
        end
      end
      default: begin
        mem_stage_out.dmem_rdata = MAX_XLEN'(rdata_reg);
        state_next               = IDLE;
      end
    endcase
  end

  // Reset must silence the port immediately, not at the next edge.
  assign dmem_req   = req_raw   && !arst;
  assign stall      = stall_raw && !arst;
  assign misaligned = mis_raw   && !arst;

  a_rvalid_in_wait : assert property (
    @(posedge clk) disable iff (arst) dmem_rvalid |-> (state_reg == WAIT)
  ) else $error("mem_stage_lsu: rvalid outside WAIT ignored");

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;
  import mem_stage_pkg::*;

  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // 32-bit instance
  logic           v32;
  mem_stage_in_t  in32;
  mem_stage_out_t out32;
  logic           stall32, mis32, req32, we32, gnt32, rvalid32;
  logic [31:0]    addr32, wdata32, rdata32;
  logic [3:0]     be32;

  // 64-bit instance
  logic           v64;
  mem_stage_in_t  in64;
  mem_stage_out_t out64;
  logic           stall64, mis64, req64, we64, gnt64, rvalid64;
  logic [31:0]    addr64;
  logic [63:0]    wdata64, rdata64;
  logic [7:0]     be64;

  mem_stage_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut32 (
    .clk(clk), .arst(arst), .in_valid(v32), .mem_stage_in(in32), .mem_stage_out(out32),
    .stall(stall32), .misaligned(mis32), .dmem_req(req32), .dmem_we(we32),
    .dmem_addr(addr32), .dmem_be(be32), .dmem_wdata(wdata32), .dmem_gnt(gnt32),
    .dmem_rvalid(rvalid32), .dmem_rdata(rdata32)
  );

  mem_stage_lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut64 (
    .clk(clk), .arst(arst), .in_valid(v64), .mem_stage_in(in64), .mem_stage_out(out64),
    .stall(stall64), .misaligned(mis64), .dmem_req(req64), .dmem_we(we64),
    .dmem_addr(addr64), .dmem_be(be64), .dmem_wdata(wdata64), .dmem_gnt(gnt64),
    .dmem_rvalid(rvalid64), .dmem_rdata(rdata64)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic mem_stage_in_t mk_op(input logic rd_op, input logic wr_op, input mem_size_e sz,
                                          input logic uns, input logic [63:0] addr,
                                          input logic [63:0] data);
    mem_stage_in_t t;
    t              = '0;
    t.opr_res      = addr;
    t.rs2_data     = data;
    t.rd           = 5'd7;
    t.wb_en        = rd_op;
    t.wb_sel       = 2'd1;
    t.mem_rd       = rd_op;
    t.mem_wr       = wr_op;
    t.mem_size     = sz;
    t.mem_unsigned = uns;
    return t;
  endfunction

  task automatic test_reset();
    v32 = 1'b1;
    in32 = mk_op(1'b1, 1'b0, SIZE_H, 1'b0, 64'h101, 64'h0);
    #2;
    n_cmp++; if (mis32 !== 1'b0) begin n_bad++; $display("FAIL reset_mis: got %b want 0", mis32); end
    n_cmp++; if (stall32 !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall32); end
    in32 = mk_op(1'b0, 1'b1, SIZE_W, 1'b0, 64'h104, 64'h1);
    #1;
    n_cmp++; if (req32 !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", req32); end
    $display("reset: mis=%b stall=%b req=%b", mis32, stall32, req32);
    tick();
    v32 = 1'b0;
    arst = 1'b0;
    #1;
  endtask

  task automatic test_passthru();
    tick();
    v32 = 1'b1;
    in32 = '0;
    in32.opr_res = 64'h1234;
    in32.rd = 5'd5;
    in32.wb_en = 1'b1;
    in32.wb_sel = 2'd2;
    #1;
    n_cmp++; if (stall32 !== 1'b0) begin n_bad++; $display("FAIL add_stall: got %b want 0", stall32); end
    n_cmp++; if (req32 !== 1'b0) begin n_bad++; $display("FAIL add_req: got %b want 0", req32); end
    n_cmp++; if (out32.opr_res[31:0] !== 32'h1234) begin n_bad++; $display("FAIL add_res: got %h want 00001234", out32.opr_res[31:0]); end
    n_cmp++; if (out32.rd !== 5'd5 || out32.wb_en !== 1'b1 || out32.wb_sel !== 2'd2) begin n_bad++; $display("FAIL add_fields: got rd=%0d wb_en=%b sel=%0d want 5 1 2", out32.rd, out32.wb_en, out32.wb_sel); end
    n_cmp++; if (out32.dmem_rdata !== 64'h0) begin n_bad++; $display("FAIL add_rdata: got %h want 0", out32.dmem_rdata); end
    $display("add: res=%h stall=%b req=%b", out32.opr_res[31:0], stall32, req32);
    tick();
    v32 = 1'b0;
  endtask

  task automatic test_store_word();
    tick();
    v32 = 1'b1;
    in32 = mk_op(1'b0, 1'b1, SIZE_W, 1'b0, 64'h104, 64'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      gnt32 = (i == 3);
      #1;
      n_cmp++; if (req32 !== 1'b1 || stall32 !== 1'b1) begin n_bad++; $display("FAIL sw_req_c%0d: got req=%b stall=%b want 1 1", i, req32, stall32); end
    end
    n_cmp++; if (be32 !== 4'b1111 || we32 !== 1'b1) begin n_bad++; $display("FAIL sw_be: got be=%b we=%b want 1111 1", be32, we32); end
    n_cmp++; if (wdata32 !== 32'hDEADBEEF || addr32 !== 32'h104) begin n_bad++; $display("FAIL sw_data: got %h @%h want deadbeef @00000104", wdata32, addr32); end
    tick();
    gnt32 = 1'b0;
    #1;
    n_cmp++; if (stall32 !== 1'b0 || req32 !== 1'b0) begin n_bad++; $display("FAIL sw_resp: got stall=%b req=%b want 0 0", stall32, req32); end
    $display("sw: be=%b wdata=%h resp_stall=%b", be32, wdata32, stall32);
    tick();
    v32 = 1'b0;
  endtask

  task automatic test_load_byte(input logic uns, input logic [31:0] exp);
    tick();
    v32 = 1'b1;
    in32 = mk_op(1'b1, 1'b0, SIZE_B, uns, 64'h103, 64'h0);
    gnt32 = 1'b1;
    #1;
    n_cmp++; if (req32 !== 1'b1 || be32 !== 4'b1000 || addr32 !== 32'h100) begin n_bad++; $display("FAIL lb_req: got req=%b be=%b addr=%h want 1 1000 00000100", req32, be32, addr32); end
    tick();
    gnt32 = 1'b0;
    #1;
    n_cmp++; if (stall32 !== 1'b1 || req32 !== 1'b0) begin n_bad++; $display("FAIL lb_wait: got stall=%b req=%b want 1 0", stall32, req32); end
    tick();
    rvalid32 = 1'b1;
    rdata32 = 32'h80FF_0000;
    #1;
    n_cmp++; if (stall32 !== 1'b1) begin n_bad++; $display("FAIL lb_wait2: got stall=%b want 1", stall32); end
    tick();
    rvalid32 = 1'b0;
    rdata32 = '0;
    #1;
    n_cmp++; if (stall32 !== 1'b0 || out32.dmem_rdata[31:0] !== exp) begin n_bad++; $display("FAIL lb_data u=%b: got stall=%b data=%h want 0 %h", uns, stall32, out32.dmem_rdata[31:0], exp); end
    $display("lb uns=%b: data=%h", uns, out32.dmem_rdata[31:0]);
    tick();
    v32 = 1'b0;
  endtask

  task automatic test_half_and_misalign();
    tick();
    v32 = 1'b1;
    in32 = mk_op(1'b0, 1'b1, SIZE_H, 1'b0, 64'h102, 64'hABCD);
    gnt32 = 1'b1;
    #1;
    n_cmp++; if (be32 !== 4'b1100 || wdata32 !== 32'hABCDABCD) begin n_bad++; $display("FAIL sh: got be=%b wdata=%h want 1100 abcdabcd", be32, wdata32); end
    tick();
    gnt32 = 1'b0;
    #1;
    n_cmp++; if (stall32 !== 1'b0) begin n_bad++; $display("FAIL sh_resp: got stall=%b want 0", stall32); end
    $display("sh: be=%b wdata=%h", be32, wdata32);
    tick();
    in32 = mk_op(1'b1, 1'b0, SIZE_H, 1'b0, 64'h101, 64'h0);
    #1;
    n_cmp++; if (mis32 !== 1'b1 || req32 !== 1'b0) begin n_bad++; $display("FAIL lh_mis: got mis=%b req=%b want 1 0", mis32, req32); end
    n_cmp++; if (out32.wb_en !== 1'b0 || stall32 !== 1'b0) begin n_bad++; $display("FAIL lh_wb: got wb_en=%b stall=%b want 0 0", out32.wb_en, stall32); end
    $display("lh misaligned: mis=%b wb_en=%b", mis32, out32.wb_en);
    tick();
    v32 = 1'b0;
    #1;
    n_cmp++; if (mis32 !== 1'b0) begin n_bad++; $display("FAIL lh_once: got mis=%b want 0", mis32); end
    tick();
    v32 = 1'b1;
    in32 = mk_op(1'b1, 1'b0, SIZE_D, 1'b0, 64'h100, 64'h0);
    #1;
    n_cmp++; if (mis32 !== 1'b1 || req32 !== 1'b0) begin n_bad++; $display("FAIL ld32_mis: got mis=%b req=%b want 1 0", mis32, req32); end
    $display("ld on 32-bit: mis=%b", mis32);
    tick();
    v32 = 1'b0;
  endtask

  task automatic test_wide_load(input mem_size_e sz, input logic [63:0] addr, input logic [63:0] raw,
                                input logic [7:0] exp_be, input logic [63:0] exp);
    tick();
    v64 = 1'b1;
    in64 = mk_op(1'b1, 1'b0, sz, 1'b0, addr, 64'h0);
    gnt64 = 1'b1;
    #1;
    n_cmp++; if (req64 !== 1'b1 || be64 !== exp_be || addr64 !== 32'h8) begin n_bad++; $display("FAIL w64_req: got req=%b be=%h addr=%h want 1 %h 00000008", req64, be64, addr64, exp_be); end
    tick();
    gnt64 = 1'b0;
    rvalid64 = 1'b1;
    rdata64 = raw;
    #1;
    n_cmp++; if (stall64 !== 1'b1) begin n_bad++; $display("FAIL w64_wait: got stall=%b want 1", stall64); end
    tick();
    rvalid64 = 1'b0;
    rdata64 = '0;
    #1;
    n_cmp++; if (stall64 !== 1'b0 || out64.dmem_rdata !== exp) begin n_bad++; $display("FAIL w64_data: got stall=%b data=%h want 0 %h", stall64, out64.dmem_rdata, exp); end
    $display("w64 size=%0d addr=%h: be=%h data=%h", sz, addr, exp_be, out64.dmem_rdata);
    tick();
    v64 = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    tick();
    v32 = 1'b1;
    in32 = mk_op(1'b1, 1'b0, SIZE_W, 1'b0, 64'h200, 64'h0);
    gnt32 = 1'b1;
    #1;
    n_cmp++; if (req32 !== 1'b1) begin n_bad++; $display("FAIL rst_req: got %b want 1", req32); end
    tick();
    gnt32 = 1'b0;
    #1;
    n_cmp++; if (stall32 !== 1'b1) begin n_bad++; $display("FAIL rst_wait: got stall=%b want 1", stall32); end
    #1;
    arst = 1'b1;
    #1;
    n_cmp++; if (stall32 !== 1'b0 || req32 !== 1'b0) begin n_bad++; $display("FAIL rst_async: got stall=%b req=%b want 0 0", stall32, req32); end
    tick();
    rvalid32 = 1'b1;
    rdata32 = 32'h0000_0BAD;
    #1;
    n_cmp++; if (stall32 !== 1'b0 || req32 !== 1'b0) begin n_bad++; $display("FAIL rst_hold: got stall=%b req=%b want 0 0", stall32, req32); end
    tick();
    rvalid32 = 1'b0;
    rdata32 = '0;
    arst = 1'b0;
    in32 = mk_op(1'b1, 1'b0, SIZE_W, 1'b0, 64'h204, 64'h0);
    gnt32 = 1'b1;
    #1;
    n_cmp++; if (req32 !== 1'b1 || addr32 !== 32'h204) begin n_bad++; $display("FAIL rst_relw: got req=%b addr=%h want 1 00000204", req32, addr32); end
    tick();
    gnt32 = 1'b0;
    rvalid32 = 1'b1;
    rdata32 = 32'h1357_2468;
    #1;
    tick();
    rvalid32 = 1'b0;
    rdata32 = '0;
    #1;
    n_cmp++; if (stall32 !== 1'b0 || out32.dmem_rdata[31:0] !== 32'h1357_2468) begin n_bad++; $display("FAIL rst_lw_data: got stall=%b data=%h want 0 13572468", stall32, out32.dmem_rdata[31:0]); end
    $display("reset mid-access then lw: data=%h", out32.dmem_rdata[31:0]);
    tick();
    v32 = 1'b0;
  endtask

  initial begin
    v32 = 1'b0; in32 = '0; gnt32 = 1'b0; rvalid32 = 1'b0; rdata32 = '0;
    v64 = 1'b0; in64 = '0; gnt64 = 1'b0; rvalid64 = 1'b0; rdata64 = '0;
    test_reset();
    test_passthru();
    test_store_word();
    test_load_byte(1'b0, 32'hFFFF_FF80);
    test_load_byte(1'b1, 32'h0000_0080);
    test_half_and_misalign();
    test_wide_load(SIZE_D, 64'h8, 64'h1122_3344_5566_7788, 8'hFF, 64'h1122_3344_5566_7788);
    test_wide_load(SIZE_W, 64'hC, 64'h89AB_CDEF_0123_4567, 8'hF0, 64'hFFFF_FFFF_89AB_CDEF);
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
